// File: rtl/sdf_unit5_span.sv
// Radix-5 single-path delay-feedback FFT stage with configurable span,
// per-block forward/inverse mode, self-timed drain and truncated-block abort.

module butterfly5 #(
   parameter int WIDTH = 14
) (
   input  logic [WIDTH-1:0] x_re [5],
   input  logic [WIDTH-1:0] x_im [5],
   output logic [WIDTH-1:0] y_re [5],
   output logic [WIDTH-1:0] y_im [5]
);
   localparam int AW   = WIDTH + 20;
   localparam int FRAC = 14;

   // Twiddles W^r = exp(-j*2*pi*r/5) in Q2.14
   function automatic logic signed [15:0] tw_c(input int unsigned r);
      case (r)
         0:       return 16'sd16384;
         1, 4:    return 16'sd5063;
         default: return -16'sd13255;
      endcase
   endfunction

   function automatic logic signed [15:0] tw_s(input int unsigned r);
      case (r)
         0:       return 16'sd0;
         1:       return -16'sd15582;
         2:       return -16'sd9630;
         3:       return 16'sd9630;
         default: return 16'sd15582;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] rnd(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] t;
      t = (a + AW'(2 ** (FRAC - 1))) >>> FRAC;
      return t[WIDTH-1:0];
   endfunction

   logic signed [AW-1:0] acc_re, acc_im;

   always_comb begin
      acc_re = '0;
      acc_im = '0;
      for (int unsigned j = 0; j < 5; j++) begin
         acc_re = '0;
         acc_im = '0;
         for (int unsigned m = 0; m < 5; m++) begin
            acc_re = acc_re + AW'($signed(x_re[m])) * AW'(tw_c((m * j) % 5))
                            - AW'($signed(x_im[m])) * AW'(tw_s((m * j) % 5));
            acc_im = acc_im + AW'($signed(x_re[m])) * AW'(tw_s((m * j) % 5))
                            + AW'($signed(x_im[m])) * AW'(tw_c((m * j) % 5));
         end
         y_re[j] = rnd(acc_re);
         y_im[j] = rnd(acc_im);
      end
   end
endmodule

module sdf_unit5_span #(
   parameter int WIDTH = 14,
   parameter int SPAN  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             di_en,
   input  logic [WIDTH-1:0] di_re,
   input  logic [WIDTH-1:0] di_im,
   input  logic             inv,
   output logic             do_en,
   output logic [WIDTH-1:0] do_re,
   output logic [WIDTH-1:0] do_im,
   output logic             err
);
   localparam int CW    = (SPAN > 1) ? $clog2(SPAN) : 1;
   localparam int DEPTH = 1 << CW;
   localparam logic [CW-1:0] K_LAST = CW'(SPAN - 1);

   typedef enum logic {DRN_IDLE, DRN_RUN} drn_state_t;

   logic [2:0]       p;
   logic [CW-1:0]    k;
   logic             mode;
   drn_state_t       drn_state, drn_state_nx;
   logic [1:0]       dq, dq_nx;
   logic [CW-1:0]    dk, dk_nx;
   logic [WIDTH-1:0] dl_re [4][DEPTH];
   logic [WIDTH-1:0] dl_im [4][DEPTH];
   logic [WIDTH-1:0] bi_re [5];
   logic [WIDTH-1:0] bi_im [5];
   logic [WIDTH-1:0] bo_re [5];
   logic [WIDTH-1:0] bo_im [5];
   logic             ph4, blk_done;

   assign ph4      = di_en && (p == 3'd4);
   assign blk_done = ph4 && (k == K_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         p    <= '0;
         k    <= '0;
         mode <= 1'b0;
         err  <= 1'b0;
      end else begin
         err <= 1'b0;
         if (di_en) begin
            if (p == 3'd0 && k == '0)
               mode <= inv;
            if (k == K_LAST) begin
               k <= '0;
               p <= (p == 3'd4) ? 3'd0 : p + 3'd1;
            end else begin
               k <= k + CW'(1);
            end
         end else if (p != 3'd0 || k != '0) begin
            p   <= '0;
            k   <= '0;
            err <= 1'b1;
         end
      end
   end

   // Inverse mode: swapping re/im on both sides of a forward DFT-5 gives the inverse
   always_comb begin
      for (int unsigned m = 0; m < 4; m++) begin
         bi_re[m] = mode ? dl_im[m][k] : dl_re[m][k];
         bi_im[m] = mode ? dl_re[m][k] : dl_im[m][k];
      end
      bi_re[4] = mode ? di_im : di_re;
      bi_im[4] = mode ? di_re : di_im;
   end

   butterfly5 #(.WIDTH(WIDTH)) u_bf (
      .x_re(bi_re),
      .x_im(bi_im),
      .y_re(bo_re),
      .y_im(bo_im)
   );

   // A following block writes each path slot no earlier than the drain reads it;
   // same-cycle read sees the old word, so paths are shared without conflict.
   always_ff @(posedge clk) begin
      if (di_en) begin
         if (p != 3'd4) begin
            dl_re[p[1:0]][k] <= di_re;
            dl_im[p[1:0]][k] <= di_im;
         end else begin
            for (int unsigned q = 0; q < 4; q++) begin
               dl_re[q][k] <= mode ? bo_im[q+1] : bo_re[q+1];
               dl_im[q][k] <= mode ? bo_re[q+1] : bo_im[q+1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drn_state <= DRN_IDLE;
         dq        <= '0;
         dk        <= '0;
      end else begin
         drn_state <= drn_state_nx;
         dq        <= dq_nx;
         dk        <= dk_nx;
      end
   end

   always_comb begin
      drn_state_nx = drn_state;
      dq_nx        = dq;
      dk_nx        = dk;
      if (drn_state == DRN_RUN) begin
         if (dk == K_LAST) begin
            dk_nx = '0;
            if (dq == 2'd3)
               drn_state_nx = DRN_IDLE;
            else
               dq_nx = dq + 2'd1;
         end else begin
            dk_nx = dk + CW'(1);
         end
      end
      if (blk_done) begin
         drn_state_nx = DRN_RUN;
         dq_nx        = '0;
         dk_nx        = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         do_en <= 1'b0;
         do_re <= '0;
         do_im <= '0;
      end else begin
         do_en <= 1'b0;
         do_re <= '0;
         do_im <= '0;
         if (ph4) begin
            do_en <= 1'b1;
            do_re <= mode ? bo_im[0] : bo_re[0];
            do_im <= mode ? bo_re[0] : bo_im[0];
         end else if (drn_state == DRN_RUN) begin
            do_en <= 1'b1;
            do_re <= dl_re[dq][dk];
            do_im <= dl_im[dq][dk];
         end
      end
   end
endmodule

// File: tb/tb_sdf_unit5_span.sv
// Bench for sdf_unit5_span: three instances (SPAN 1/2/4) checked cycle by cycle
// against a direct DFT-5 block model and a per-step expected output timeline.

module tb_sdf_unit5_span;
   localparam int W  = 14;
   localparam int NS = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_v [3];
   logic         en_v  [3];
   logic         inv_v [3];
   logic         den_v [3];
   logic         err_v [3];
   logic [W-1:0] re_v  [3];
   logic [W-1:0] im_v  [3];
   logic [W-1:0] dre_v [3];
   logic [W-1:0] dim_v [3];

   sdf_unit5_span #(.WIDTH(W), .SPAN(1)) u_s1 (
      .clk(clk), .rst(rst_v[0]), .di_en(en_v[0]), .di_re(re_v[0]), .di_im(im_v[0]),
      .inv(inv_v[0]), .do_en(den_v[0]), .do_re(dre_v[0]), .do_im(dim_v[0]), .err(err_v[0]));
   sdf_unit5_span #(.WIDTH(W), .SPAN(2)) u_s2 (
      .clk(clk), .rst(rst_v[1]), .di_en(en_v[1]), .di_re(re_v[1]), .di_im(im_v[1]),
      .inv(inv_v[1]), .do_en(den_v[1]), .do_re(dre_v[1]), .do_im(dim_v[1]), .err(err_v[1]));
   sdf_unit5_span #(.WIDTH(W), .SPAN(4)) u_s4 (
      .clk(clk), .rst(rst_v[2]), .di_en(en_v[2]), .di_re(re_v[2]), .di_im(im_v[2]),
      .inv(inv_v[2]), .do_en(den_v[2]), .do_re(dre_v[2]), .do_im(dim_v[2]), .err(err_v[2]));

   int errors = 0;
   int checks = 0;
   longint tw_c [5];
   longint tw_s [5];

   // schedule: step t drives s_* and expects e_* (output registered at edge t-1)
   int nt;
   logic         s_rst [NS];
   logic         s_en  [NS];
   logic         s_inv [NS];
   logic [W-1:0] s_re  [NS];
   logic [W-1:0] s_im  [NS];
   logic         e_en  [NS];
   logic         e_err [NS];
   logic [W-1:0] e_re  [NS];
   logic [W-1:0] e_im  [NS];
   logic [W-1:0] blk_re [$];
   logic [W-1:0] blk_im [$];

   // y[j] = round(sum_m x[m] * exp(-+j*2*pi*m*j/5)) with Q14 twiddles, wrapped to W bits
   function automatic void dft5(input logic iv, input longint xr [5], input longint xi [5],
                                output logic [W-1:0] yr [5], output logic [W-1:0] yi [5]);
      longint ar, ai, c, s, q;
      for (int j = 0; j < 5; j++) begin
         ar = 0;
         ai = 0;
         for (int m = 0; m < 5; m++) begin
            c  = tw_c[(m * j) % 5];
            s  = iv ? -tw_s[(m * j) % 5] : tw_s[(m * j) % 5];
            ar = ar + xr[m] * c - xi[m] * s;
            ai = ai + xr[m] * s + xi[m] * c;
         end
         q = (ar + 8192) >>> 14;
         yr[j] = q[W-1:0];
         q = (ai + 8192) >>> 14;
         yi[j] = q[W-1:0];
      end
   endfunction

   task automatic clear_sched(input int n);
      nt = n;
      for (int t = 0; t < NS; t++) begin
         s_rst[t] = 1'b0;
         s_en[t]  = 1'b0;
         s_inv[t] = 1'($urandom);
         s_re[t]  = W'($urandom);
         s_im[t]  = W'($urandom);
         e_en[t]  = 1'b0;
         e_err[t] = 1'b0;
         e_re[t]  = '0;
         e_im[t]  = '0;
      end
   endtask

   task automatic fill_rand(input int s);
      blk_re.delete();
      blk_im.delete();
      for (int i = 0; i < 5 * s; i++) begin
         blk_re.push_back(W'($urandom));
         blk_im.push_back(W'($urandom));
      end
   endtask

   task automatic add_block(input int t0, input int s, input logic iv);
      longint xr [5];
      longint xi [5];
      logic [W-1:0] yr [5];
      logic [W-1:0] yi [5];
      int t;
      for (int i = 0; i < 5 * s; i++) begin
         s_en[t0+i]  = 1'b1;
         s_re[t0+i]  = blk_re[i];
         s_im[t0+i]  = blk_im[i];
         s_inv[t0+i] = (i == 0) ? iv : 1'($urandom);
      end
      for (int k = 0; k < s; k++) begin
         for (int m = 0; m < 5; m++) begin
            xr[m] = longint'($signed(blk_re[m*s+k]));
            xi[m] = longint'($signed(blk_im[m*s+k]));
         end
         dft5(iv, xr, xi, yr, yi);
         for (int j = 0; j < 5; j++) begin
            t = t0 + 4 * s + 1 + j * s + k;
            e_en[t] = 1'b1;
            e_re[t] = yr[j];
            e_im[t] = yi[j];
         end
      end
   endtask

   task automatic add_abort(input int t0, input int n);
      for (int i = 0; i < n; i++)
         s_en[t0+i] = 1'b1;
      e_err[t0+n+1] = 1'b1;
   endtask

   task automatic add_reset(input int tr);
      s_rst[tr] = 1'b1;
      s_en[tr]  = 1'b0;
      for (int t = tr + 1; t < NS; t++) begin
         e_en[t]  = 1'b0;
         e_err[t] = 1'b0;
         e_re[t]  = '0;
         e_im[t]  = '0;
      end
   endtask

   task automatic step(input int u, input logic r, input logic e, input logic iv,
                       input logic [W-1:0] xr, input logic [W-1:0] xi,
                       output logic oe, output logic oerr,
                       output logic [W-1:0] ore, output logic [W-1:0] oim);
      @(negedge clk);
      oe   = den_v[u];
      oerr = err_v[u];
      ore  = dre_v[u];
      oim  = dim_v[u];
      rst_v[u] = r;
      en_v[u]  = e;
      inv_v[u] = iv;
      re_v[u]  = xr;
      im_v[u]  = xi;
   endtask

   task automatic test_reset();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      for (int u = 0; u < 3; u++) begin
         step(u, 1'b1, 1'b0, 1'b0, '0, '0, oe, oerr, ore, oim);
         step(u, 1'b0, 1'b0, 1'b0, '0, '0, oe, oerr, ore, oim);
         checks++;
         if (oe !== 1'b0 || oerr !== 1'b0 || ore !== '0 || oim !== '0) begin
            errors++;
            $display("FAIL reset u%0d: got en=%b err=%b %0d,%0d want 0 0 0,0", u, oe, oerr, ore, oim);
         end
      end
   endtask

   task automatic test_impulse();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      int first = -1;
      clear_sched(13);
      blk_re = '{W'(100), W'(0), W'(0), W'(0), W'(0)};
      blk_im = '{W'(0), W'(0), W'(0), W'(0), W'(0)};
      add_block(1, 1, 1'b0);
      for (int t = 0; t < nt; t++) begin
         step(0, s_rst[t], s_en[t], s_inv[t], s_re[t], s_im[t], oe, oerr, ore, oim);
         if (oe === 1'b1 && first < 0) first = t;
         checks++;
         if (oe !== e_en[t] || ore !== e_re[t] || oim !== e_im[t] || oerr !== e_err[t]) begin
            errors++;
            $display("FAIL impulse t=%0d: got en=%b err=%b %0d,%0d want en=%b err=%b %0d,%0d",
                     t, oe, oerr, $signed(ore), $signed(oim), e_en[t], e_err[t], $signed(e_re[t]), $signed(e_im[t]));
         end
         if (oe === 1'b1) begin
            checks++;
            if (ore !== W'(100) || oim !== '0) begin
               errors++;
               $display("FAIL impulse_value t=%0d: got %0d,%0d want 100,0", t, $signed(ore), $signed(oim));
            end
         end
      end
      checks++;
      if (first != 6) begin
         errors++;
         $display("FAIL impulse_latency: got first do_en at step %0d want 6", first);
      end
   endtask

   task automatic test_dc();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      int first = -1;
      clear_sched(40);
      blk_re.delete();
      blk_im.delete();
      for (int i = 0; i < 20; i++) begin
         blk_re.push_back(W'(10));
         blk_im.push_back(W'(0));
      end
      add_block(1, 4, 1'b0);
      for (int t = 0; t < nt; t++) begin
         step(2, s_rst[t], s_en[t], s_inv[t], s_re[t], s_im[t], oe, oerr, ore, oim);
         if (oe === 1'b1 && first < 0) first = t;
         checks++;
         if (oe !== e_en[t] || ore !== e_re[t] || oim !== e_im[t] || oerr !== e_err[t]) begin
            errors++;
            $display("FAIL dc t=%0d: got en=%b err=%b %0d,%0d want en=%b err=%b %0d,%0d",
                     t, oe, oerr, $signed(ore), $signed(oim), e_en[t], e_err[t], $signed(e_re[t]), $signed(e_im[t]));
         end
         if (oe === 1'b1) begin
            checks++;
            if (ore !== ((t < 22) ? W'(50) : W'(0)) || oim !== '0) begin
               errors++;
               $display("FAIL dc_value t=%0d: got %0d,%0d want %0d,0", t, $signed(ore), $signed(oim), (t < 22) ? 50 : 0);
            end
         end
      end
      checks++;
      if (first != 18) begin
         errors++;
         $display("FAIL dc_latency: got first do_en at step %0d want 18", first);
      end
   endtask

   task automatic test_back_to_back();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      int n_en = 0;
      int n_drain = 0;
      clear_sched(42);
      for (int b = 0; b < 3; b++) begin
         fill_rand(2);
         add_block(1 + 10 * b, 2, 1'($urandom));
      end
      for (int t = 0; t < nt; t++) begin
         step(1, s_rst[t], s_en[t], s_inv[t], s_re[t], s_im[t], oe, oerr, ore, oim);
         if (oe === 1'b1) n_en++;
         if (oe === 1'b1 && t > 0 && !s_en[t-1]) n_drain++;
         checks++;
         if (oe !== e_en[t] || ore !== e_re[t] || oim !== e_im[t] || oerr !== e_err[t]) begin
            errors++;
            $display("FAIL back_to_back t=%0d: got en=%b err=%b %0d,%0d want en=%b err=%b %0d,%0d",
                     t, oe, oerr, $signed(ore), $signed(oim), e_en[t], e_err[t], $signed(e_re[t]), $signed(e_im[t]));
         end
      end
      checks++;
      if (n_en != 30 || n_drain != 8) begin
         errors++;
         $display("FAIL back_to_back_count: got %0d outputs, %0d with di_en low; want 30, 8", n_en, n_drain);
      end
   endtask

   task automatic test_inverse();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      clear_sched(18);
      blk_re = '{W'(0), W'(0), W'(0), W'(0), W'(0)};
      blk_im = '{W'(0), W'(50), W'(0), W'(0), W'(0)};
      add_block(1, 1, 1'b0);
      add_block(6, 1, 1'b1);
      for (int t = 0; t < nt; t++) begin
         step(0, s_rst[t], s_en[t], s_inv[t], s_re[t], s_im[t], oe, oerr, ore, oim);
         checks++;
         if (oe !== e_en[t] || ore !== e_re[t] || oim !== e_im[t] || oerr !== e_err[t]) begin
            errors++;
            $display("FAIL inverse t=%0d: got en=%b err=%b %0d,%0d want en=%b err=%b %0d,%0d",
                     t, oe, oerr, $signed(ore), $signed(oim), e_en[t], e_err[t], $signed(e_re[t]), $signed(e_im[t]));
         end
      end
   endtask

   task automatic test_abort();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      int n_err = 0;
      clear_sched(40);
      fill_rand(2);
      add_block(1, 2, 1'($urandom));
      add_abort(11, 6);
      fill_rand(2);
      add_block(19, 2, 1'($urandom));
      for (int t = 0; t < nt; t++) begin
         step(1, s_rst[t], s_en[t], s_inv[t], s_re[t], s_im[t], oe, oerr, ore, oim);
         if (oerr === 1'b1) n_err++;
         checks++;
         if (oe !== e_en[t] || ore !== e_re[t] || oim !== e_im[t] || oerr !== e_err[t]) begin
            errors++;
            $display("FAIL abort t=%0d: got en=%b err=%b %0d,%0d want en=%b err=%b %0d,%0d",
                     t, oe, oerr, $signed(ore), $signed(oim), e_en[t], e_err[t], $signed(e_re[t]), $signed(e_im[t]));
         end
      end
      checks++;
      if (n_err != 1) begin
         errors++;
         $display("FAIL abort_err_count: got %0d pulses want 1", n_err);
      end
   endtask

   task automatic test_reset_drain();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      int first = -1;
      clear_sched(38);
      fill_rand(2);
      add_block(1, 2, 1'($urandom));
      add_reset(14);
      fill_rand(2);
      add_block(17, 2, 1'($urandom));
      for (int t = 0; t < nt; t++) begin
         step(1, s_rst[t], s_en[t], s_inv[t], s_re[t], s_im[t], oe, oerr, ore, oim);
         if (t > 14 && oe === 1'b1 && first < 0) first = t;
         checks++;
         if (oe !== e_en[t] || ore !== e_re[t] || oim !== e_im[t] || oerr !== e_err[t]) begin
            errors++;
            $display("FAIL reset_drain t=%0d: got en=%b err=%b %0d,%0d want en=%b err=%b %0d,%0d",
                     t, oe, oerr, $signed(ore), $signed(oim), e_en[t], e_err[t], $signed(e_re[t]), $signed(e_im[t]));
         end
      end
      checks++;
      if (first != 26) begin
         errors++;
         $display("FAIL reset_drain_latency: got first do_en after reset at step %0d want 26", first);
      end
   endtask

   task automatic test_random();
      logic oe, oerr;
      logic [W-1:0] ore, oim;
      int s, t0;
      for (int u = 0; u < 3; u++) begin
         s = (u == 0) ? 1 : (u == 1) ? 2 : 4;
         clear_sched(NS);
         t0 = 1;
         for (int b = 0; b < 3; b++) begin
            fill_rand(s);
            add_block(t0, s, 1'($urandom));
            t0 = t0 + 5 * s + int'($urandom_range(0, 3));
         end
         nt = t0 + 9 * s + 4;
         for (int t = 0; t < nt; t++) begin
            step(u, s_rst[t], s_en[t], s_inv[t], s_re[t], s_im[t], oe, oerr, ore, oim);
            checks++;
            if (oe !== e_en[t] || ore !== e_re[t] || oim !== e_im[t] || oerr !== e_err[t]) begin
               errors++;
               $display("FAIL random u%0d t=%0d: got en=%b err=%b %0d,%0d want en=%b err=%b %0d,%0d",
                        u, t, oe, oerr, $signed(ore), $signed(oim), e_en[t], e_err[t], $signed(e_re[t]), $signed(e_im[t]));
            end
         end
      end
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         rst_v[u] = 1'b0;
         en_v[u]  = 1'b0;
         inv_v[u] = 1'b0;
         re_v[u]  = '0;
         im_v[u]  = '0;
      end
      for (int r = 0; r < 5; r++) begin
         tw_c[r] = longint'(int'(16384.0 * $cos(2.0 * 3.14159265358979 * r / 5.0)));
         tw_s[r] = longint'(int'(-16384.0 * $sin(2.0 * 3.14159265358979 * r / 5.0)));
      end
      test_reset();
      test_impulse();
      test_dc();
      test_back_to_back();
      test_inverse();
      test_abort();
      test_reset_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
